decode_stage_param: RTL and testbench



---
 rtl/decode_stage_param_if.sv | 59 +++++
 rtl/decode_stage_param.sv | 119 +++++++++++
 tb/tb_decode_stage_param.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_param_if.sv
// Decode/execute boundary bundle: decode-side inputs, write-back port,
// pipeline control, hazard stall and the registered execute-stage outputs.
interface decode_stage_param_if #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 24,
    parameter int INSTR_W    = 34,
    parameter int REG_ADDR_W = 4,
    parameter int CTRL_W     = 8
);
    // decode-stage inputs
    logic [INSTR_W-1:0]    instr_d;
    logic                  valid_d;
    logic [CTRL_W-1:0]     ctrl_d;
    logic [DATA_W-1:0]     imm_ext_d;
    logic [ADDR_W-1:0]     pc_d;
    logic [ADDR_W-1:0]     pc_plus4_d;

    // write-back port
    logic                  reg_write_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic [DATA_W-1:0]     result_w;

    // pipeline control
    logic                  stall_in;
    logic                  flush_e;
    logic                  stall_fd;

    // execute-stage register contents
    logic                  valid_e;
    logic [CTRL_W-1:0]     ctrl_e;
    logic [DATA_W-1:0]     rd1_e;
    logic [DATA_W-1:0]     rd2_e;
    logic [DATA_W-1:0]     imm_ext_e;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [ADDR_W-1:0]     pc_e;
    logic [ADDR_W-1:0]     pc_plus4_e;

    // upstream side (fetch/decode, write-back, control)
    modport master (
        output instr_d, valid_d, ctrl_d, imm_ext_d, pc_d, pc_plus4_d,
        output reg_write_w, rd_w, result_w,
        output stall_in, flush_e,
        input  stall_fd,
        input  valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e,
        input  rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e
    );

    // the decode stage itself
    modport slave (
        input  instr_d, valid_d, ctrl_d, imm_ext_d, pc_d, pc_plus4_d,
        input  reg_write_w, rd_w, result_w,
        input  stall_in, flush_e,
        output stall_fd,
        output valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e,
        output rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e
    );
endinterface

// File: rtl/decode_stage_param.sv
// Decode stage: register file with write-back bypass, load-use hazard
// detection, and the D/E pipeline register with stall/flush handling.
module decode_stage_param #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 24,
    parameter int INSTR_W    = 34,
    parameter int REG_ADDR_W = 4,
    parameter int RS1_LSB    = 25,
    parameter int RS2_LSB    = 21,
    parameter int RD_LSB     = 0,
    parameter int CTRL_W     = 8,
    parameter int LOAD_BIT   = 3
) (
    input logic                  clk,
    input logic                  rst,
    decode_stage_param_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2**REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [DATA_W-1:0]     rd1_d;
    logic [DATA_W-1:0]     rd2_d;
    logic                  hz;
    logic                  de_update;
    logic                  de_bubble;

    // Register index fields of the decode instruction
    always_comb begin
        rs1_d = bus.instr_d[RS1_LSB +: REG_ADDR_W];
        rs2_d = bus.instr_d[RS2_LSB +: REG_ADDR_W];
        rd_d  = bus.instr_d[RD_LSB  +: REG_ADDR_W];
    end

    // Register file write port; r0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.reg_write_w && bus.rd_w != '0) begin
            regs[bus.rd_w] <= bus.result_w;
        end
    end

    // Read ports with same-cycle write-back bypass; r0 reads as zero
    always_comb begin
        if (rs1_d == '0) begin
            rd1_d = '0;
        end else if (bus.reg_write_w && bus.rd_w == rs1_d) begin
            rd1_d = bus.result_w;
        end else begin
            rd1_d = regs[rs1_d];
        end

        if (rs2_d == '0) begin
            rd2_d = '0;
        end else if (bus.reg_write_w && bus.rd_w == rs2_d) begin
            rd2_d = bus.result_w;
        end else begin
            rd2_d = regs[rs2_d];
        end
    end

    // Load-use hazard: a load in E whose destination a valid decode instruction reads
    always_comb begin
        hz = bus.valid_e && bus.ctrl_e[LOAD_BIT] && (bus.rd_e != '0) && bus.valid_d &&
             ((bus.rd_e == rs1_d) || (bus.rd_e == rs2_d));
        bus.stall_fd = hz && !bus.flush_e;
    end

    // D/E update decision: flush beats stall_in, stall_in beats the hazard bubble
    always_comb begin
        de_update = bus.flush_e || !bus.stall_in;
        de_bubble = bus.flush_e || hz;
    end

    // D/E pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid_e    <= 1'b0;
            bus.ctrl_e     <= '0;
            bus.rd1_e      <= '0;
            bus.rd2_e      <= '0;
            bus.imm_ext_e  <= '0;
            bus.rs1_e      <= '0;
            bus.rs2_e      <= '0;
            bus.rd_e       <= '0;
            bus.pc_e       <= '0;
            bus.pc_plus4_e <= '0;
        end else if (de_update) begin
            if (de_bubble) begin
                bus.valid_e    <= 1'b0;
                bus.ctrl_e     <= '0;
                bus.rd1_e      <= '0;
                bus.rd2_e      <= '0;
                bus.imm_ext_e  <= '0;
                bus.rs1_e      <= '0;
                bus.rs2_e      <= '0;
                bus.rd_e       <= '0;
                bus.pc_e       <= '0;
                bus.pc_plus4_e <= '0;
            end else begin
                bus.valid_e    <= bus.valid_d;
                bus.ctrl_e     <= bus.valid_d ? bus.ctrl_d : '0;
                bus.rd1_e      <= rd1_d;
                bus.rd2_e      <= rd2_d;
                bus.imm_ext_e  <= bus.imm_ext_d;
                bus.rs1_e      <= rs1_d;
                bus.rs2_e      <= rs2_d;
                bus.rd_e       <= rd_d;
                bus.pc_e       <= bus.pc_d;
                bus.pc_plus4_e <= bus.pc_plus4_d;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage_param.sv
// Randomized self-checking bench for decode_stage_param against a
// behavioural pipeline model, plus directed literal checks.
module tb_decode_stage_param;
    localparam int DATA_W     = 24;
    localparam int ADDR_W     = 24;
    localparam int INSTR_W    = 34;
    localparam int REG_ADDR_W = 4;
    localparam int RS1_LSB    = 25;
    localparam int RS2_LSB    = 21;
    localparam int RD_LSB     = 0;
    localparam int CTRL_W     = 8;
    localparam int LOAD_BIT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    decode_stage_param_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
        .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)
    ) bus ();

    decode_stage_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
        .REG_ADDR_W(REG_ADDR_W), .RS1_LSB(RS1_LSB), .RS2_LSB(RS2_LSB),
        .RD_LSB(RD_LSB), .CTRL_W(CTRL_W), .LOAD_BIT(LOAD_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // expected execute-stage contents
    typedef struct packed {
        logic                  valid;
        logic [CTRL_W-1:0]     ctrl;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [ADDR_W-1:0]     pc;
        logic [ADDR_W-1:0]     pc4;
    } e_t;

    e_t              me;
    logic [DATA_W-1:0] mregs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] f_rs1();
        return bus.instr_d[RS1_LSB +: 4];
    endfunction
    function automatic logic [3:0] f_rs2();
        return bus.instr_d[RS2_LSB +: 4];
    endfunction
    function automatic logic [3:0] f_rd();
        return bus.instr_d[RD_LSB +: 4];
    endfunction

    // value a source operand must see this cycle
    function automatic logic [DATA_W-1:0] m_read(input logic [3:0] idx);
        if (idx == 4'd0) return '0;
        if (bus.reg_write_w && bus.rd_w == idx) return bus.result_w;
        return mregs[idx];
    endfunction

    function automatic bit m_hz();
        return me.valid && me.ctrl[LOAD_BIT] && me.rd != 4'd0 && bus.valid_d &&
               (me.rd == f_rs1() || me.rd == f_rs2());
    endfunction

    task automatic model_reset();
        me = '0;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
    endtask

    // advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        e_t nxt;
        nxt = me;
        if (bus.flush_e || (!bus.stall_in && m_hz())) begin
            nxt = '0;
        end else if (!bus.stall_in) begin
            nxt.valid = bus.valid_d;
            nxt.ctrl  = bus.valid_d ? bus.ctrl_d : '0;
            nxt.rd1   = m_read(f_rs1());
            nxt.rd2   = m_read(f_rs2());
            nxt.imm   = bus.imm_ext_d;
            nxt.rs1   = f_rs1();
            nxt.rs2   = f_rs2();
            nxt.rd    = f_rd();
            nxt.pc    = bus.pc_d;
            nxt.pc4   = bus.pc_plus4_d;
        end
        if (bus.reg_write_w && bus.rd_w != 4'd0) mregs[bus.rd_w] = bus.result_w;
        me = nxt;
    endtask

    // compare DUT against model every cycle, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_e",    64'(bus.valid_e),    64'(me.valid));
            chk("ctrl_e",     64'(bus.ctrl_e),     64'(me.ctrl));
            chk("rd1_e",      64'(bus.rd1_e),      64'(me.rd1));
            chk("rd2_e",      64'(bus.rd2_e),      64'(me.rd2));
            chk("imm_ext_e",  64'(bus.imm_ext_e),  64'(me.imm));
            chk("rs1_e",      64'(bus.rs1_e),      64'(me.rs1));
            chk("rs2_e",      64'(bus.rs2_e),      64'(me.rs2));
            chk("rd_e",       64'(bus.rd_e),       64'(me.rd));
            chk("pc_e",       64'(bus.pc_e),       64'(me.pc));
            chk("pc_plus4_e", 64'(bus.pc_plus4_e), 64'(me.pc4));
            chk("stall_fd",   64'(bus.stall_fd),   64'(m_hz() && !bus.flush_e));
        end
    end

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        #2;
    endtask

    task automatic set_idle();
        bus.instr_d     = '0;
        bus.valid_d     = 1'b0;
        bus.ctrl_d      = '0;
        bus.imm_ext_d   = '0;
        bus.pc_d        = '0;
        bus.pc_plus4_d  = '0;
        bus.reg_write_w = 1'b0;
        bus.rd_w        = '0;
        bus.result_w    = '0;
        bus.stall_in    = 1'b0;
        bus.flush_e     = 1'b0;
    endtask

    task automatic set_dec(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                           input logic [CTRL_W-1:0] ctrl, input logic [ADDR_W-1:0] pc,
                           input logic valid);
        logic [63:0] r;
        logic [INSTR_W-1:0] v;
        r = {$urandom, $urandom};
        v = r[INSTR_W-1:0];
        v[RS1_LSB +: 4] = rs1;
        v[RS2_LSB +: 4] = rs2;
        v[RD_LSB  +: 4] = rd;
        bus.instr_d    = v;
        bus.ctrl_d     = ctrl;
        bus.valid_d    = valid;
        bus.imm_ext_d  = DATA_W'($urandom);
        bus.pc_d       = pc;
        bus.pc_plus4_d = pc + ADDR_W'(4);
    endtask

    function automatic logic [3:0] rnd_idx();
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    logic [DATA_W-1:0] wv [16];

    initial begin
        set_idle();
        model_reset();
        rst = 1'b0;
        #1;
        chk("reset valid_e",  64'(bus.valid_e), 64'(0));
        chk("reset pc_e",     64'(bus.pc_e), 64'(0));
        chk("reset stall_fd", 64'(bus.stall_fd), 64'(0));
        @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        // write all 16 registers
        for (int i = 0; i < 16; i++) wv[i] = DATA_W'($urandom);
        wv[0] = 24'hFFFFFF;
        wv[5] = 24'h00ABCD;
        for (int i = 0; i < 16; i++) begin
            set_idle();
            bus.reg_write_w = 1'b1;
            bus.rd_w        = 4'(i);
            bus.result_w    = wv[i];
            cycle();
        end
        // read them back through rs1
        for (int i = 0; i < 16; i++) begin
            set_idle();
            set_dec(4'(i), 4'd0, 4'd1, '0, ADDR_W'(i * 4), 1'b1);
            cycle();
            chk("readback rd1_e", 64'(bus.rd1_e), (i == 0) ? 64'(0) : 64'(wv[i]));
        end
        set_dec(4'd5, 4'd0, 4'd1, '0, 24'h10, 1'b1);
        cycle();
        chk("r5 readback", 64'(bus.rd1_e), 64'h00ABCD);
        set_dec(4'd0, 4'd0, 4'd1, '0, 24'h14, 1'b1);
        cycle();
        chk("r0 readback", 64'(bus.rd1_e), 64'h0);

        // same-cycle bypass
        set_dec(4'd1, 4'd7, 4'd2, '0, 24'h20, 1'b1);
        bus.reg_write_w = 1'b1;
        bus.rd_w        = 4'd7;
        bus.result_w    = 24'h123456;
        cycle();
        chk("bypass rd2_e", 64'(bus.rd2_e), 64'h123456);
        bus.reg_write_w = 1'b0;

        // load-use: one bubble, then the held instruction enters E
        set_dec(4'd0, 4'd0, 4'd3, 8'h08, 24'h30, 1'b1);
        cycle();
        set_dec(4'd3, 4'd9, 4'd4, 8'h00, 24'h100, 1'b1);
        #1;
        chk("load-use stall_fd", 64'(bus.stall_fd), 64'(1));
        cycle();
        chk("bubble valid_e", 64'(bus.valid_e), 64'(0));
        chk("bubble ctrl_e",  64'(bus.ctrl_e), 64'(0));
        #1;
        chk("stall_fd cleared", 64'(bus.stall_fd), 64'(0));
        cycle();
        chk("held valid_e", 64'(bus.valid_e), 64'(1));
        chk("held pc_e",    64'(bus.pc_e), 64'h100);
        chk("held rs1_e",   64'(bus.rs1_e), 64'(3));

        // flush
        set_dec(4'd1, 4'd2, 4'd5, 8'h01, 24'h40, 1'b1);
        bus.flush_e = 1'b1;
        cycle();
        chk("flush valid_e", 64'(bus.valid_e), 64'(0));
        chk("flush pc_e",    64'(bus.pc_e), 64'(0));
        bus.flush_e = 1'b0;

        // flush together with a hazard
        set_dec(4'd0, 4'd0, 4'd3, 8'h08, 24'h44, 1'b1);
        cycle();
        set_dec(4'd3, 4'd0, 4'd6, 8'h00, 24'h48, 1'b1);
        bus.flush_e = 1'b1;
        #1;
        chk("flush+hz stall_fd", 64'(bus.stall_fd), 64'(0));
        cycle();
        chk("flush+hz valid_e", 64'(bus.valid_e), 64'(0));
        bus.flush_e = 1'b0;

        // stall_in held three cycles
        set_dec(4'd1, 4'd2, 4'd7, 8'h02, 24'h200, 1'b1);
        cycle();
        chk("pre-stall pc_e", 64'(bus.pc_e), 64'h200);
        for (int i = 0; i < 3; i++) begin
            set_dec(rnd_idx(), rnd_idx(), rnd_idx(), CTRL_W'($urandom), ADDR_W'($urandom), 1'b1);
            bus.stall_in = 1'b1;
            cycle();
            chk("stall pc_e",    64'(bus.pc_e), 64'h200);
            chk("stall valid_e", 64'(bus.valid_e), 64'(1));
        end
        set_dec(4'd1, 4'd2, 4'd8, 8'h00, 24'h300, 1'b1);
        bus.stall_in = 1'b0;
        cycle();
        chk("post-stall pc_e", 64'(bus.pc_e), 64'h300);

        // flush beats stall_in
        bus.stall_in = 1'b1;
        bus.flush_e  = 1'b1;
        cycle();
        chk("flush+stall valid_e", 64'(bus.valid_e), 64'(0));
        bus.stall_in = 1'b0;
        bus.flush_e  = 1'b0;

        // async reset pulse mid-stream
        set_dec(4'd1, 4'd2, 4'd9, 8'h05, 24'h400, 1'b1);
        cycle();
        chk("pre-reset valid_e", 64'(bus.valid_e), 64'(1));
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async valid_e",  64'(bus.valid_e), 64'(0));
        chk("async ctrl_e",   64'(bus.ctrl_e), 64'(0));
        chk("async pc_e",     64'(bus.pc_e), 64'(0));
        chk("async rd_e",     64'(bus.rd_e), 64'(0));
        chk("async stall_fd", 64'(bus.stall_fd), 64'(0));
        @(negedge clk);
        #2;
        rst = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_dec(rnd_idx(), rnd_idx(), rnd_idx(),
                    CTRL_W'($urandom) | (($urandom_range(0, 9) < 4) ? CTRL_W'(1 << LOAD_BIT) : '0),
                    ADDR_W'($urandom), ($urandom_range(0, 9) < 8));
            bus.reg_write_w = ($urandom_range(0, 1) == 1);
            bus.rd_w        = rnd_idx();
            bus.result_w    = DATA_W'($urandom);
            bus.stall_in    = ($urandom_range(0, 99) < 15);
            bus.flush_e     = ($urandom_range(0, 99) < 10);
            cycle();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
